// File: rtl/eeg_fram_loader.sv
`default_nettype none
// ============================================================================
// Module   : eeg_fram_loader
// Brief    : Unpacks chip input bytes into feature words and writes them
//            round-robin into the enabled feature-RAM banks.
// Revision : 1.0 - initial release
// ============================================================================
module eeg_fram_loader #(
    parameter int CHIP_DAT_DW = 8,
    parameter int BANK_NUM_DW = 4,
    parameter int FRAM_DAT_DW = 4,
    parameter int FRAM_ADD_AW = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 CFG_START,
    input  logic [FRAM_ADD_AW:0]                 CFG_LEN,
    input  logic [BANK_NUM_DW-1:0]               CFG_BANK_MSK,
    input  logic                                 CHIP_DAT_VLD,
    output logic                                 CHIP_DAT_RDY,
    input  logic [CHIP_DAT_DW-1:0]               CHIP_DAT_DAT,
    output logic [BANK_NUM_DW-1:0]               ETOF_DAT_VLD,
    input  logic [BANK_NUM_DW-1:0]               ETOF_DAT_RDY,
    output logic [BANK_NUM_DW*FRAM_ADD_AW-1:0]   ETOF_DAT_ADD,
    output logic [BANK_NUM_DW*FRAM_DAT_DW-1:0]   ETOF_DAT_DAT,
    output logic                                 LOAD_BUSY,
    output logic                                 LOAD_DONE
);

    localparam int NPB = CHIP_DAT_DW / FRAM_DAT_DW;
    localparam int BIW = (BANK_NUM_DW > 1) ? $clog2(BANK_NUM_DW) : 1;
    localparam int PCW = $clog2(BANK_NUM_DW + 1);
    localparam int CNW = $clog2(NPB + 1);
    localparam int WLW = FRAM_ADD_AW + 1 + PCW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                               state_q, state_d;
    logic [BANK_NUM_DW-1:0]                   msk_q, msk_d;
    logic [BIW-1:0]                           bank_q, bank_d;
    logic [FRAM_ADD_AW-1:0]                   addr_q, addr_d;
    logic [WLW-1:0]                           wr_left_q, wr_left_d;
    logic [WLW-1:0]                           fetch_left_q, fetch_left_d;
    logic [CHIP_DAT_DW-1:0]                   buf_q, buf_d;
    logic [CNW-1:0]                           buf_cnt_q, buf_cnt_d;
    logic [BANK_NUM_DW-1:0]                   vld_q, vld_d;
    logic [BANK_NUM_DW-1:0][FRAM_ADD_AW-1:0]  add_q, add_d;
    logic [BANK_NUM_DW-1:0][FRAM_DAT_DW-1:0]  dat_q, dat_d;

    logic                                     w_hs;
    logic                                     w_last_hs;
    logic                                     w_out_free;
    logic                                     w_chip_rdy;
    logic                                     w_byte_acc;
    logic                                     w_present;
    logic [FRAM_DAT_DW-1:0]                   w_nib;
    logic [BIW:0]                             w_next;
    logic [WLW-1:0]                           w_total;

    function automatic logic [PCW-1:0] popcount(input logic [BANK_NUM_DW-1:0] msk);
        logic [PCW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BANK_NUM_DW; i++) begin
            cnt = cnt + PCW'(msk[i]);
        end
        return cnt;
    endfunction

    function automatic logic [BIW-1:0] lowest_bank(input logic [BANK_NUM_DW-1:0] msk);
        logic [BIW-1:0] idx;
        idx = '0;
        for (int i = BANK_NUM_DW - 1; i >= 0; i--) begin
            if (msk[i]) idx = BIW'(i);
        end
        return idx;
    endfunction

    // MSB of the result flags a wrap back to the lowest bank, i.e. a new address row.
    function automatic logic [BIW:0] next_bank(input logic [BANK_NUM_DW-1:0] msk,
                                               input logic [BIW-1:0]         cur);
        logic [BIW-1:0] lo;
        logic [BIW-1:0] hi;
        logic           hi_ok;
        lo    = '0;
        hi    = '0;
        hi_ok = 1'b0;
        for (int i = BANK_NUM_DW - 1; i >= 0; i--) begin
            if (msk[i]) begin
                lo = BIW'(i);
                if (i > int'(cur)) begin
                    hi    = BIW'(i);
                    hi_ok = 1'b1;
                end
            end
        end
        return hi_ok ? {1'b0, hi} : {1'b1, lo};
    endfunction

    assign w_total    = WLW'(CFG_LEN) * WLW'(popcount(CFG_BANK_MSK));
    assign w_next     = next_bank(msk_q, bank_q);
    assign w_hs       = |(vld_q & ETOF_DAT_RDY);
    assign w_last_hs  = w_hs && (wr_left_q == WLW'(1));
    assign w_out_free = (vld_q == '0) || w_hs;
    assign w_chip_rdy = (state_q == S_LOAD) && (fetch_left_q != '0) && (buf_cnt_q == '0)
                        && w_out_free && !w_last_hs;
    assign w_byte_acc = w_chip_rdy && CHIP_DAT_VLD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (CFG_START) begin
                    state_d = ((CFG_LEN == '0) || (CFG_BANK_MSK == '0)) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last_hs) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        LOAD_BUSY    = (state_q == S_LOAD);
        LOAD_DONE    = (state_q == S_DONE);
        CHIP_DAT_RDY = w_chip_rdy;
        ETOF_DAT_VLD = vld_q;
        ETOF_DAT_ADD = add_q;
        ETOF_DAT_DAT = dat_q;
    end

    always_comb begin
        msk_d        = msk_q;
        bank_d       = bank_q;
        addr_d       = addr_q;
        wr_left_d    = wr_left_q;
        fetch_left_d = fetch_left_q;
        buf_d        = buf_q;
        buf_cnt_d    = buf_cnt_q;
        vld_d        = vld_q;
        add_d        = add_q;
        dat_d        = dat_q;
        w_present    = 1'b0;
        w_nib        = '0;

        if ((state_q == S_IDLE) && CFG_START) begin
            msk_d        = CFG_BANK_MSK;
            bank_d       = lowest_bank(CFG_BANK_MSK);
            addr_d       = '0;
            wr_left_d    = w_total;
            fetch_left_d = w_total;
            buf_cnt_d    = '0;
            vld_d        = '0;
        end else if (state_q == S_LOAD) begin
            if (w_hs) begin
                wr_left_d = wr_left_q - WLW'(1);
                vld_d     = '0;
            end
            // Nibbles still buffered after the final write are simply dropped.
            if (w_last_hs) begin
                buf_cnt_d = '0;
            end else if (w_out_free) begin
                if (buf_cnt_q != '0) begin
                    w_present = 1'b1;
                    w_nib     = buf_q[FRAM_DAT_DW-1:0];
                    buf_d     = buf_q >> FRAM_DAT_DW;
                    buf_cnt_d = buf_cnt_q - CNW'(1);
                end else if (w_byte_acc) begin
                    w_present    = 1'b1;
                    w_nib        = CHIP_DAT_DAT[FRAM_DAT_DW-1:0];
                    buf_d        = CHIP_DAT_DAT >> FRAM_DAT_DW;
                    buf_cnt_d    = CNW'(NPB - 1);
                    fetch_left_d = (fetch_left_q > WLW'(NPB)) ? fetch_left_q - WLW'(NPB) : '0;
                end
            end
            if (w_present) begin
                vld_d         = '0;
                vld_d[bank_q] = 1'b1;
                add_d[bank_q] = addr_q;
                dat_d[bank_q] = w_nib;
                bank_d        = w_next[BIW-1:0];
                if (w_next[BIW]) addr_d = addr_q + FRAM_ADD_AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msk_q        <= '0;
            bank_q       <= '0;
            addr_q       <= '0;
            wr_left_q    <= '0;
            fetch_left_q <= '0;
            buf_q        <= '0;
            buf_cnt_q    <= '0;
            vld_q        <= '0;
            add_q        <= '0;
            dat_q        <= '0;
        end else begin
            msk_q        <= msk_d;
            bank_q       <= bank_d;
            addr_q       <= addr_d;
            wr_left_q    <= wr_left_d;
            fetch_left_q <= fetch_left_d;
            buf_q        <= buf_d;
            buf_cnt_q    <= buf_cnt_d;
            vld_q        <= vld_d;
            add_q        <= add_d;
            dat_q        <= dat_d;
        end
    end

endmodule
`default_nettype wire
